// File: rtl/flow_led_pkg.sv
// Shared status encoding for the control FSM and the flowing-light driver.
// Also holds the direction encoding used when FLOW_BOUNCE_EN is defined.
package flow_led_pkg;

    localparam int STATUS_W = 2;

    typedef logic [STATUS_W-1:0] status_t;

    localparam status_t ST_LOW   = 2'd0;
    localparam status_t ST_MID   = 2'd1;
    localparam status_t ST_HIGH  = 2'd2;
    localparam status_t ST_PAUSE = 2'd3;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/flow_led_driver_if.sv
// Status-in / pattern-out bundle between the control side (master) and the LED driver (slave).
interface flow_led_driver_if
    import flow_led_pkg::*;
#(
    parameter int N_LED = 8
);

    status_t            status;
    logic [N_LED-1:0]   led;
    logic               tick;
    logic               paused;

    modport master (output status, input led, input tick, input paused);
    modport slave  (input status, output led, output tick, output paused);

endinterface

// File: rtl/flow_led_driver_step_prescaler.sv
// Speed-selected step timer: picks the divider from status, counts, holds while paused,
// and strobes step on the edge where the pattern must advance.
module step_prescaler
    import flow_led_pkg::*;
#(
    parameter int DIV_LOW  = 50_000_000,
    parameter int DIV_MID  = 25_000_000,
    parameter int DIV_HIGH = 12_500_000
) (
    input  logic    clk,
    input  logic    rst_n,
    input  status_t status,
    output logic    step
);

    localparam int CNT_W = (DIV_LOW > 1) ? $clog2(DIV_LOW) : 1;

    localparam logic [CNT_W-1:0] LOW_M1  = CNT_W'(DIV_LOW - 1);
    localparam logic [CNT_W-1:0] MID_M1  = CNT_W'(DIV_MID - 1);
    localparam logic [CNT_W-1:0] HIGH_M1 = CNT_W'(DIV_HIGH - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] div_m1;
    logic             hold;

    always_comb begin
        div_m1 = LOW_M1;
        hold   = 1'b0;
        case (status)
            ST_LOW:  div_m1 = LOW_M1;
            ST_MID:  div_m1 = MID_M1;
            ST_HIGH: div_m1 = HIGH_M1;
            default: hold   = 1'b1;
        endcase
    end

    // ">=" lets a speed-up fire immediately when the held count already exceeds the new limit.
    always_comb begin
        step  = !hold && (cnt_q >= div_m1);
        cnt_d = cnt_q;
        if (!hold) begin
            cnt_d = step ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/flow_led_driver.sv
// One-hot flowing-light driver with speed/pause control and an exported step pulse.
// Define FLOW_BOUNCE_EN for a ping-pong pattern instead of the circular rotate.
module flow_led_driver
    import flow_led_pkg::*;
#(
    parameter int N_LED    = 8,
    parameter int DIV_LOW  = 50_000_000,
    parameter int DIV_MID  = 25_000_000,
    parameter int DIV_HIGH = 12_500_000
) (
    input  logic              clk,
    input  logic              rst_n,
    flow_led_driver_if.slave  bus
);

    logic             step;
    logic [N_LED-1:0] led_q;
    logic [N_LED-1:0] led_d;
    logic             tick_q;
    logic             tick_d;
    logic             paused_q;
    logic             paused_d;

    step_prescaler #(
        .DIV_LOW  (DIV_LOW),
        .DIV_MID  (DIV_MID),
        .DIV_HIGH (DIV_HIGH)
    ) u_step_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .status (bus.status),
        .step   (step)
    );

`ifdef FLOW_BOUNCE_EN
    logic dir_q;
    logic dir_d;

    // Direction flips on the edge that lights an end LED, so each end shows for one step only.
    always_comb begin
        led_d = led_q;
        dir_d = dir_q;
        if (step) begin
            if (dir_q == DIR_LEFT) begin
                led_d = led_q << 1;
                if (led_d[N_LED-1]) dir_d = DIR_RIGHT;
            end else begin
                led_d = led_q >> 1;
                if (led_d[0]) dir_d = DIR_LEFT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_q <= DIR_LEFT;
        end else begin
            dir_q <= dir_d;
        end
    end
`else
    always_comb begin
        led_d = led_q;
        if (step) begin
            led_d = {led_q[N_LED-2:0], led_q[N_LED-1]};
        end
    end
`endif

    always_comb begin
        tick_d   = step;
        paused_d = (bus.status == ST_PAUSE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_q    <= N_LED'(1);
            tick_q   <= 1'b0;
            paused_q <= 1'b0;
        end else begin
            led_q    <= led_d;
            tick_q   <= tick_d;
            paused_q <= paused_d;
        end
    end

    assign bus.led    = led_q;
    assign bus.tick   = tick_q;
    assign bus.paused = paused_q;

endmodule

// File: tb/tb_flow_led_driver.sv
// Directed vector bench for flow_led_driver with N_LED=4 and dividers 8/4/2.
module tb_flow_led_driver;
    import flow_led_pkg::*;

    typedef struct {
        logic [1:0] status;
        logic [3:0] led;
        logic       tick;
        logic       paused;
    } vec_t;

    logic clk;
    logic rst_n;
    int unsigned n_checks;
    int unsigned n_errors;
    vec_t vecs[$];

    flow_led_driver_if #(.N_LED(4)) bus ();

    flow_led_driver #(
        .N_LED    (4),
        .DIV_LOW  (8),
        .DIV_MID  (4),
        .DIV_HIGH (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic [1:0] st, input logic [3:0] led, input logic tk,
                       input logic ps, input int unsigned reps);
        for (int unsigned i = 0; i < reps; i++) vecs.push_back('{st, led, tk, ps});
    endtask

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;

`ifdef FLOW_BOUNCE_EN
        add(2, 4'b0001, 0, 0, 1); add(2, 4'b0010, 1, 0, 1);
        add(2, 4'b0010, 0, 0, 1); add(2, 4'b0100, 1, 0, 1);
        add(2, 4'b0100, 0, 0, 1); add(2, 4'b1000, 1, 0, 1);
        add(2, 4'b1000, 0, 0, 1); add(2, 4'b0100, 1, 0, 1);
        add(2, 4'b0100, 0, 0, 1); add(2, 4'b0010, 1, 0, 1);
        add(2, 4'b0010, 0, 0, 1); add(2, 4'b0001, 1, 0, 1);
        add(2, 4'b0001, 0, 0, 1); add(2, 4'b0010, 1, 0, 1);
`else
        // First step after the 4th edge at mid speed.
        add(1, 4'b0001, 0, 0, 3); add(1, 4'b0010, 1, 0, 1);
        // High speed, including the MSB->LSB wrap.
        add(2, 4'b0010, 0, 0, 1); add(2, 4'b0100, 1, 0, 1);
        add(2, 4'b0100, 0, 0, 1); add(2, 4'b1000, 1, 0, 1);
        add(2, 4'b1000, 0, 0, 1); add(2, 4'b0001, 1, 0, 1);
        add(2, 4'b0001, 0, 0, 1); add(2, 4'b0010, 1, 0, 1);
        // Count to 2 at mid, pause 10 cycles, resume from the held count.
        add(1, 4'b0010, 0, 0, 2);
        add(3, 4'b0010, 0, 1, 10);
        add(1, 4'b0010, 0, 0, 1); add(1, 4'b0100, 1, 0, 1);
        // Count to 5 at low, then high speed fires on the very next edge.
        add(0, 4'b0100, 0, 0, 5);
        add(2, 4'b1000, 1, 0, 1); add(2, 4'b1000, 0, 0, 1);
        add(2, 4'b0001, 1, 0, 1); add(2, 4'b0001, 0, 0, 1);
        add(2, 4'b0010, 1, 0, 1); add(2, 4'b0010, 0, 0, 1);
        add(2, 4'b0100, 1, 0, 1);
`endif

        rst_n      = 1'b0;
        bus.status = vecs[0].status;
        #12;
        chk("reset_led", bus.led, 4'b0001);
        chk("reset_tick", bus.tick, 0);
        chk("reset_paused", bus.paused, 0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            bus.status = vecs[i].status;
            edge_sample();
            chk($sformatf("vec%0d_led", i), bus.led, vecs[i].led);
            chk($sformatf("vec%0d_tick", i), bus.tick, vecs[i].tick);
            chk($sformatf("vec%0d_paused", i), bus.paused, vecs[i].paused);
        end

        // Asynchronous reset with tick high: clears without any clock edge.
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_led", bus.led, 4'b0001);
        chk("async_rst_tick", bus.tick, 0);
        chk("async_rst_paused", bus.paused, 0);
        bus.status = ST_HIGH;
        #2 rst_n = 1'b1;
        edge_sample();
        chk("post_rst1_tick", bus.tick, 0);
        chk("post_rst1_led", bus.led, 4'b0001);
        edge_sample();
        chk("post_rst2_tick", bus.tick, 1);
        chk("post_rst2_led", bus.led, 4'b0010);
        edge_sample();
        chk("pre_rst_tick", bus.tick, 0);

        // Reset with the count mid-way: no pending step may survive.
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_led", bus.led, 4'b0001);
        #2 rst_n = 1'b1;
        edge_sample();
        chk("rst_mid_e1_tick", bus.tick, 0);
        chk("rst_mid_e1_led", bus.led, 4'b0001);
        edge_sample();
        chk("rst_mid_e2_tick", bus.tick, 1);
        chk("rst_mid_e2_led", bus.led, 4'b0010);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
